ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter for the mouse port. It sends one command byte at a time, for example 0xF4 (enable data reporting) or 0xFF (reset), to the PS/2 mouse. It handles the request-to-send inhibit, device-clocked bit shifting, odd parity, stop bit and acknowledge check. It shares the PS2Clk/PS2Data open-drain lines with the existing mouse receiver: this block drives only output-enables, and the top level builds the tristates (line driven low when enable = 1, released otherwise).

## Interface
Parameters:
- INHIBIT_CYCLES, 13000, clk cycles the host holds PS/2 clock low (100 µs at 130 MHz)
- TIMEOUT_CYCLES, 2600000, max clk cycles between device clock falling edges (20 ms at 130 MHz)

Ports:
- clk  in  1  system clock (130 MHz domain of the mouse controller)
- rst  in  1  synchronous, active-high reset
- tx_data  in  8  command byte, sampled at handshake
- tx_valid  in  1  request to send
- tx_ready  out  1  idle, can accept a byte
- ps2_clk_in  in  1  raw PS/2 clock line (asynchronous)
- ps2_data_in  in  1  raw PS/2 data line (asynchronous)
- ps2_clk_oe  out  1  1 = pull PS/2 clock low
- ps2_data_oe  out  1  1 = pull PS/2 data low
- tx_done  out  1  1-cycle pulse: byte sent and ACKed
- tx_err  out  1  1-cycle pulse: NACK or timeout

## Operation
- Handshake: a byte is accepted on a clk edge with tx_valid & tx_ready, and tx_data is latched on that edge. tx_valid while busy is ignored.
- Line inputs: 2-flop synchronizer, then falling-edge detect on the synchronized clock.
- States:
  - IDLE: tx_ready=1, both oe=0. On accept → INHIBIT.
  - INHIBIT: clk_oe=1 for INHIBIT_CYCLES cycles → REQ.
  - REQ: clk_oe=1 and data_oe=1 (start bit) for exactly 1 cycle → SHIFT.
  - SHIFT: clk_oe=0, data_oe stays 1. Each device clock falling edge advances bit index k=0..9:
    - k=0..7 drive bit k of the latched byte, LSB first, with data_oe = ~bit.
    - k=8 drives odd parity p = ~^tx_data, with data_oe = ~p.
    - k=9 releases data (stop bit), data_oe=0.
  - SHIFT → ACK after the 10th falling edge.
  - ACK: on the 11th falling edge, sample synchronized data. 0 → WAIT_IDLE; 1 → ERR.
  - WAIT_IDLE: wait until synchronized clock=1 and data=1, then → DONE.
  - DONE: tx_done=1 for one cycle → IDLE.
  - ERR: tx_err=1 for one cycle, both oe=0 → IDLE.
- Timeout: a counter clears on entry to SHIFT and on every falling edge. If it reaches TIMEOUT_CYCLES in SHIFT, ACK or WAIT_IDLE → ERR.
- Falling edges seen in IDLE (device-to-host traffic) are ignored. The host never arbitrates mid-byte.
- Reset mid-operation: on the next edge both oe=0, state IDLE, counters clear. The device recovers on its own timeout.

## Timing
- Reset values: tx_ready=1, ps2_clk_oe=0, ps2_data_oe=0, tx_done=0, tx_err=0.
- Accept on edge N gives tx_ready=0 and clk_oe=1 from N+1.
- Clock held low for INHIBIT_CYCLES+1 cycles in total: INHIBIT, then REQ.
- clk_oe falls at N+INHIBIT_CYCLES+2, with data_oe already 1.
- Input latency: 2 cycles through the synchronizer, edge flag on the 3rd. data_oe updates on the clk edge after the edge flag, well inside the ≥5 µs PS/2 low phase.
- tx_done and tx_err are mutually exclusive. They are never asserted in the same cycle as tx_ready=1 from a new accept; tx_ready rises the cycle after the pulse.
- Counter widths are $clog2 of the parameter plus 1; they saturate and do not wrap.

## Configuration
- PS2_TX_CLK_FILTER_EN:
  - Defined: an 8-cycle glitch filter follows the synchronizer on the clock input. The level changes only after 8 consecutive equal samples. Input latency becomes 10 cycles.
  - Undefined: synchronizer only, latency as above.
- The data input is never filtered.

## Structure
- Shared package ps2_pkg:
  - state enum (IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE, DONE, ERR)
  - PS2 command constants CMD_RESET=8'hFF, CMD_ENABLE=8'hF4
  - odd-parity function
- Sub-module ps2_line_sync: synchronizer, optional filter and falling-edge detect for one line. It is instantiated for the clock and the data line; the data instance never has the filter.

## Test plan
- Send 0xF4 with a BFM device clocking at 12.5 kHz and ACKing → bits 0,0,1,0,1,1,1,1, parity 0, stop released; tx_done pulse; tx_ready returns.
- Send 0xFF → parity bit 1 (data_oe=0 in the parity slot). Verify clock low for 13001 cycles before release.
- Device holds data high on the 11th edge (NACK) → tx_err pulse, tx_done stays 0, both oe=0.
- Device stops clocking after bit 3 → tx_err exactly TIMEOUT_CYCLES after the last falling edge; lines released.
- Assert rst during SHIFT → both oe=0 and tx_ready=1 the next cycle. A following 0xF4 transfer completes normally.
- With PS2_TX_CLK_FILTER_EN: inject 3-cycle clock glitches during SHIFT → bit index is unaffected and the byte is received correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, mouse command bytes and the parity helper.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQ,
      SHIFT,
      ACK,
      WAIT_IDLE,
      DONE,
      ERR
   } ps2_tx_state_e;

   localparam logic [7:0] CMD_RESET  = 8'hFF;
   localparam logic [7:0] CMD_ENABLE = 8'hF4;

   // Parity bit that makes the nine transmitted bits contain an odd number of ones.
   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// One PS/2 line: 2-flop synchronizer, optional 8-sample glitch filter and a registered falling-edge flag.
module ps2_line_sync #(
   parameter bit FILTER_EN = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic line_in,
   output logic level,
   output logic fall
);

   logic [1:0] sync_q, sync_d;
   logic       prev_q, prev_d;
   logic       fall_q, fall_d;
   logic       filt_level;

   generate
      if (FILTER_EN) begin : g_filt
         logic [2:0] cnt_q, cnt_d;
         logic       lvl_q, lvl_d;

         // The filtered level flips only after 8 consecutive samples disagree with it.
         always_comb begin
            lvl_d = lvl_q;
            cnt_d = '0;
            if (sync_q[1] != lvl_q) begin
               if (cnt_q == 3'd7) begin
                  lvl_d = sync_q[1];
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               lvl_q <= 1'b1;
               cnt_q <= '0;
            end else begin
               lvl_q <= lvl_d;
               cnt_q <= cnt_d;
            end
         end

         assign filt_level = lvl_q;
      end else begin : g_nofilt
         assign filt_level = sync_q[1];
      end
   endgenerate

   always_comb begin
      sync_d = {sync_q[0], line_in};
      prev_d = filt_level;
      fall_d = prev_q & ~filt_level;
   end

   // Idle PS/2 lines are pulled high, so reset assumes a released line.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= 2'b11;
         prev_q <= 1'b1;
         fall_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
         fall_q <= fall_d;
      end
   end

   assign level = filt_level;
   assign fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter; drives only open-drain output enables.
// Define PS2_TX_CLK_FILTER_EN to add an 8-cycle glitch filter on the PS/2 clock input.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 13000,
   parameter int TIMEOUT_CYCLES = 2600000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       tx_done,
   output logic       tx_err
);

   localparam int INH_W = $clog2(INHIBIT_CYCLES) + 1;
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [INH_W-1:0] INH_MAX  = INH_W'(INHIBIT_CYCLES);
   localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);

`ifdef PS2_TX_CLK_FILTER_EN
   localparam bit CLK_FILTER = 1'b1;
`else
   localparam bit CLK_FILTER = 1'b0;
`endif

   ps2_tx_state_e    state_q, state_d;
   logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic [3:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       byte_q, byte_d;
   logic             data_oe_q, data_oe_d;

   logic clk_level, clk_fall;
   logic data_level, data_fall_unused;
   logic timeout_hit;

   ps2_line_sync #(.FILTER_EN(CLK_FILTER)) u_clk_sync (
      .clk     (clk),
      .rst     (rst),
      .line_in (ps2_clk_in),
      .level   (clk_level),
      .fall    (clk_fall)
   );

   ps2_line_sync #(.FILTER_EN(1'b0)) u_data_sync (
      .clk     (clk),
      .rst     (rst),
      .line_in (ps2_data_in),
      .level   (data_level),
      .fall    (data_fall_unused)
   );

   assign timeout_hit = (to_cnt_q == TO_MAX);

   // Next-state logic; the data enable is a flop so it changes only on clk edges.
   always_comb begin
      state_d   = state_q;
      inh_cnt_d = inh_cnt_q;
      bit_idx_d = bit_idx_q;
      byte_d    = byte_q;
      data_oe_d = data_oe_q;
      if (clk_fall) begin
         to_cnt_d = '0;
      end else if (to_cnt_q != TO_MAX) begin
         to_cnt_d = to_cnt_q + 1'b1;
      end else begin
         to_cnt_d = to_cnt_q;
      end

      case (state_q)
         IDLE: begin
            data_oe_d = 1'b0;
            inh_cnt_d = '0;
            bit_idx_d = '0;
            if (tx_valid) begin
               byte_d  = tx_data;
               state_d = INHIBIT;
            end
         end
         INHIBIT: begin
            if (inh_cnt_q != INH_MAX) begin
               inh_cnt_d = inh_cnt_q + 1'b1;
            end
            if (inh_cnt_q == INH_LAST) begin
               state_d   = REQ;
               data_oe_d = 1'b1;
            end
         end
         REQ: begin
            state_d   = SHIFT;
            to_cnt_d  = '0;
            bit_idx_d = '0;
         end
         SHIFT: begin
            if (clk_fall) begin
               bit_idx_d = bit_idx_q + 4'd1;
               case (bit_idx_q)
                  4'd8:    data_oe_d = ~odd_parity(byte_q);
                  4'd9:    data_oe_d = 1'b0;
                  default: data_oe_d = ~byte_q[bit_idx_q[2:0]];
               endcase
               if (bit_idx_q == 4'd9) begin
                  state_d = ACK;
               end
            end else if (timeout_hit) begin
               state_d   = ERR;
               data_oe_d = 1'b0;
            end
         end
         ACK: begin
            if (clk_fall) begin
               state_d = data_level ? ERR : WAIT_IDLE;
            end else if (timeout_hit) begin
               state_d = ERR;
            end
         end
         WAIT_IDLE: begin
            if (clk_level && data_level) begin
               state_d = DONE;
            end else if (timeout_hit) begin
               state_d = ERR;
            end
         end
         DONE: begin
            state_d   = IDLE;
            data_oe_d = 1'b0;
         end
         ERR: begin
            state_d   = IDLE;
            data_oe_d = 1'b0;
         end
         default: begin
            state_d   = IDLE;
            data_oe_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         inh_cnt_q <= '0;
         to_cnt_q  <= '0;
         bit_idx_q <= '0;
         byte_q    <= '0;
         data_oe_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         inh_cnt_q <= inh_cnt_d;
         to_cnt_q  <= to_cnt_d;
         bit_idx_q <= bit_idx_d;
         byte_q    <= byte_d;
         data_oe_q <= data_oe_d;
      end
   end

   assign tx_ready    = (state_q == IDLE);
   assign ps2_clk_oe  = (state_q == INHIBIT) || (state_q == REQ);
   assign ps2_data_oe = data_oe_q;
   assign tx_done     = (state_q == DONE);
   assign tx_err      = (state_q == ERR);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a small PS/2 mouse model on wired-AND lines.
module tb_ps2_host_tx;

   localparam int INH  = 20;
   localparam int TO   = 300;
   localparam int HALF = 20;
`ifdef PS2_TX_CLK_FILTER_EN
   localparam int LEVEL_LAT = 10;
`else
   localparam int LEVEL_LAT = 2;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       ps2_clk_oe, ps2_data_oe;
   logic       tx_done, tx_err;
   logic       dev_clk = 1'b1;
   logic       dev_data = 1'b1;
   logic       clk_line, data_line;

   int passed = 0;
   int total  = 0;
   int done_cnt = 0;
   int err_cnt  = 0;
   int excl_viol = 0;

   assign clk_line  = ~ps2_clk_oe & dev_clk;
   assign data_line = ~ps2_data_oe & dev_data;

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
      .clk         (clk),
      .rst         (rst),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .ps2_clk_in  (clk_line),
      .ps2_data_in (data_line),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe),
      .tx_done     (tx_done),
      .tx_err      (tx_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (tx_done === 1'b1) done_cnt++;
      if (tx_err === 1'b1) err_cnt++;
      if ((tx_done && tx_err) || ((tx_done || tx_err) && tx_ready)) excl_viol++;
   end

   // Handshake one byte; returns #1 after the accepting edge.
   task automatic send_byte(input logic [7:0] d);
      @(negedge clk);
      tx_data  = d;
      tx_valid = 1'b1;
      @(posedge clk);
      #1 tx_valid = 1'b0;
   endtask

   // Counts negedges with the host clock inhibit active; stops at the first released sample.
   task automatic wait_release(output int low_cycles);
      @(negedge clk);
      low_cycles = 0;
      while (ps2_clk_oe === 1'b1 && low_cycles < 5000) begin
         low_cycles++;
         @(negedge clk);
      end
   endtask

   // Device clocking: rx[m-1] is the data line sampled just before rising edge m.
   task automatic dev_clock_edges(input int n_edges, input bit ack, input bit glitch,
                                  output logic [9:0] rx);
      rx = '0;
      for (int m = 1; m <= n_edges; m++) begin
         if (m == 11) begin
            dev_data = ack ? 1'b0 : 1'b1;
            repeat (5) @(posedge clk);
         end
         @(posedge clk);
         #1 dev_clk = 1'b0;
         repeat (HALF) @(posedge clk);
         if (m <= 10) rx[m-1] = data_line;
         #1 dev_clk = 1'b1;
         if (glitch) begin
            repeat (8) @(posedge clk);
            #1 dev_clk = 1'b0;
            repeat (3) @(posedge clk);
            #1 dev_clk = 1'b1;
            repeat (HALF - 11) @(posedge clk);
         end else begin
            repeat (HALF) @(posedge clk);
         end
      end
      dev_data = 1'b1;
   endtask

   task automatic wait_done_pulse(input int done0);
      for (int i = 0; i < 50 && done_cnt == done0; i++) @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (tx_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", tx_ready); else passed++;
      total++; if (ps2_clk_oe !== 1'b0) $display("[TB] FAIL reset_clk_oe: got %b expected 0", ps2_clk_oe); else passed++;
      total++; if (ps2_data_oe !== 1'b0) $display("[TB] FAIL reset_data_oe: got %b expected 0", ps2_data_oe); else passed++;
      total++; if (tx_done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", tx_done); else passed++;
      total++; if (tx_err !== 1'b0) $display("[TB] FAIL reset_err: got %b expected 0", tx_err); else passed++;
      rst = 1'b0;
      repeat (5) @(posedge clk);
   endtask

   // 0xF4 LSB first 0,0,1,0,1,1,1,1; five ones so parity 0; stop released.
   task automatic test_send_enable;
      int lowc, done0, err0;
      logic [9:0] rx;
      done0 = done_cnt; err0 = err_cnt;
      send_byte(8'hF4);
      total++; if ({tx_ready, ps2_clk_oe} !== 2'b01) $display("[TB] FAIL accept_outputs: got ready,clk_oe=%b expected 01", {tx_ready, ps2_clk_oe}); else passed++;
      wait_release(lowc);
      total++; if (data_line !== 1'b0) $display("[TB] FAIL start_bit: got %b expected 0", data_line); else passed++;
      tx_valid = 1'b1;
      tx_data  = 8'h00;
      dev_clock_edges(11, 1'b1, 1'b0, rx);
      tx_valid = 1'b0;
      total++; if (rx !== 10'h2F4) $display("[TB] FAIL enable_frame: got %h expected 2f4", rx); else passed++;
      wait_done_pulse(done0);
      total++; if (done_cnt - done0 !== 1) $display("[TB] FAIL enable_done: got %0d pulses expected 1", done_cnt - done0); else passed++;
      total++; if (err_cnt - err0 !== 0) $display("[TB] FAIL enable_no_err: got %0d pulses expected 0", err_cnt - err0); else passed++;
      total++; if ({tx_ready, tx_done} !== 2'b10) $display("[TB] FAIL enable_ready_after: got ready,done=%b expected 10", {tx_ready, tx_done}); else passed++;
      repeat (10) @(posedge clk);
   endtask

   // 0xFF has eight ones so parity 1 (line released in the parity slot).
   task automatic test_send_reset_cmd;
      int lowc, done0;
      logic [9:0] rx;
      done0 = done_cnt;
      send_byte(8'hFF);
      wait_release(lowc);
      total++; if (lowc !== INH + 1) $display("[TB] FAIL clk_low_cycles: got %0d expected %0d", lowc, INH + 1); else passed++;
      total++; if (ps2_data_oe !== 1'b1) $display("[TB] FAIL data_oe_at_release: got %b expected 1", ps2_data_oe); else passed++;
      dev_clock_edges(11, 1'b1, 1'b0, rx);
      total++; if (rx !== 10'h3FF) $display("[TB] FAIL reset_cmd_frame: got %h expected 3ff", rx); else passed++;
      wait_done_pulse(done0);
      total++; if (done_cnt - done0 !== 1) $display("[TB] FAIL reset_cmd_done: got %0d pulses expected 1", done_cnt - done0); else passed++;
      repeat (10) @(posedge clk);
   endtask

   task automatic test_nack;
      int lowc, done0, err0;
      logic [9:0] rx;
      done0 = done_cnt; err0 = err_cnt;
      send_byte(8'hF4);
      wait_release(lowc);
      dev_clock_edges(11, 1'b0, 1'b0, rx);
      repeat (10) @(negedge clk);
      total++; if (err_cnt - err0 !== 1) $display("[TB] FAIL nack_err: got %0d pulses expected 1", err_cnt - err0); else passed++;
      total++; if (done_cnt - done0 !== 0) $display("[TB] FAIL nack_no_done: got %0d pulses expected 0", done_cnt - done0); else passed++;
      total++; if ({ps2_clk_oe, ps2_data_oe, tx_ready} !== 3'b001) $display("[TB] FAIL nack_lines: got clk_oe,data_oe,ready=%b expected 001", {ps2_clk_oe, ps2_data_oe, tx_ready}); else passed++;
   endtask

   // Stall after the 4th falling edge: err appears LEVEL_LAT (sync) + 1 (flag) + 1 (clear) + TO + 1 (state) edges later.
   task automatic test_timeout;
      int lowc, cyc;
      logic [9:0] rx;
      send_byte(8'hF4);
      wait_release(lowc);
      dev_clock_edges(3, 1'b1, 1'b0, rx);
      total++; if (rx[2:0] !== 3'b100) $display("[TB] FAIL timeout_first_bits: got %b expected 100", rx[2:0]); else passed++;
      @(posedge clk);
      #1 dev_clk = 1'b0;
      cyc = 0;
      do begin
         @(posedge clk);
         #1 cyc++;
      end while (tx_err !== 1'b1 && cyc < 2000);
      total++; if (cyc !== LEVEL_LAT + 3 + TO) $display("[TB] FAIL timeout_latency: got %0d expected %0d", cyc, LEVEL_LAT + 3 + TO); else passed++;
      total++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) $display("[TB] FAIL timeout_lines: got %b expected 00", {ps2_clk_oe, ps2_data_oe}); else passed++;
      dev_clk = 1'b1;
      repeat (20) @(posedge clk);
   endtask

   task automatic test_reset_mid_shift;
      int lowc, done0;
      logic [9:0] rx;
      send_byte(8'hF4);
      wait_release(lowc);
      dev_clock_edges(3, 1'b1, 1'b0, rx);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      total++; if ({ps2_clk_oe, ps2_data_oe, tx_ready} !== 3'b001) $display("[TB] FAIL midreset_lines: got clk_oe,data_oe,ready=%b expected 001", {ps2_clk_oe, ps2_data_oe, tx_ready}); else passed++;
      rst = 1'b0;
      repeat (20) @(posedge clk);
      done0 = done_cnt;
      send_byte(8'hF4);
      wait_release(lowc);
      dev_clock_edges(11, 1'b1, 1'b0, rx);
      total++; if (rx !== 10'h2F4) $display("[TB] FAIL recovery_frame: got %h expected 2f4", rx); else passed++;
      wait_done_pulse(done0);
      total++; if (done_cnt - done0 !== 1) $display("[TB] FAIL recovery_done: got %0d pulses expected 1", done_cnt - done0); else passed++;
      repeat (10) @(posedge clk);
   endtask

`ifdef PS2_TX_CLK_FILTER_EN
   task automatic test_clk_glitch;
      int lowc, done0;
      logic [9:0] rx;
      done0 = done_cnt;
      send_byte(8'hF4);
      wait_release(lowc);
      dev_clock_edges(11, 1'b1, 1'b1, rx);
      total++; if (rx !== 10'h2F4) $display("[TB] FAIL glitch_frame: got %h expected 2f4", rx); else passed++;
      wait_done_pulse(done0);
      total++; if (done_cnt - done0 !== 1) $display("[TB] FAIL glitch_done: got %0d pulses expected 1", done_cnt - done0); else passed++;
      repeat (10) @(posedge clk);
   endtask
`endif

   initial begin
      test_reset();
      test_send_enable();
      test_send_reset_cmd();
      test_nack();
      test_timeout();
      test_reset_mid_shift();
`ifdef PS2_TX_CLK_FILTER_EN
      test_clk_glitch();
`endif
      total++; if (excl_viol !== 0) $display("[TB] FAIL pulse_exclusive: got %0d violations expected 0", excl_viol); else passed++;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
